// File: rtl/serial_bus_arbiter_rr_if.sv
// Serial system bus bundle between masters, arbiter and slaves.
// slave modport is the arbiter side; master modport is the bus agents side.
interface serial_bus_arbiter_rr_if #(
   parameter int N_MASTERS = 2,
   parameter int N_SLAVES  = 4
);
   logic [N_MASTERS-1:0] m_req;
   logic [N_MASTERS-1:0] m_grant;
   logic [N_MASTERS-1:0] m_mode;
   logic [N_MASTERS-1:0] m_wr_bus;
   logic [N_MASTERS-1:0] m_master_valid;
   logic [N_MASTERS-1:0] m_master_ready;
   logic [N_MASTERS-1:0] m_rd_bus;
   logic [N_MASTERS-1:0] m_slave_ready;
   logic [N_MASTERS-1:0] m_slave_valid;
   logic [N_MASTERS-1:0] m_ack;
   logic [N_SLAVES-1:0]  s_mode;
   logic [N_SLAVES-1:0]  s_wr_bus;
   logic [N_SLAVES-1:0]  s_master_valid;
   logic [N_SLAVES-1:0]  s_master_ready;
   logic [N_SLAVES-1:0]  s_rd_bus;
   logic [N_SLAVES-1:0]  s_slave_ready;
   logic [N_SLAVES-1:0]  s_slave_valid;

   modport slave (
      input  m_req, m_mode, m_wr_bus,
      input  m_master_valid, m_master_ready,
      input  s_rd_bus, s_slave_ready, s_slave_valid,
      output m_grant, m_rd_bus, m_slave_ready,
      output m_slave_valid, m_ack,
      output s_mode, s_wr_bus,
      output s_master_valid, s_master_ready
   );

   modport master (
      output m_req, m_mode, m_wr_bus,
      output m_master_valid, m_master_ready,
      output s_rd_bus, s_slave_ready, s_slave_valid,
      input  m_grant, m_rd_bus, m_slave_ready,
      input  m_slave_valid, m_ack,
      input  s_mode, s_wr_bus,
      input  s_master_valid, s_master_ready
   );
endinterface

// File: rtl/serial_bus_arbiter_rr.sv
// Round-robin serial bus arbiter with serial slave-select address decode.
// Optional idle-timeout release is enabled by defining ARB_TIMEOUT_EN.
module serial_bus_arbiter_rr #(
   parameter int N_MASTERS = 2,
   parameter int N_SLAVES  = 4,
   parameter int TIMEOUT   = 64
) (
   input  logic clk,
   input  logic rst,
   serial_bus_arbiter_rr_if.slave bus,
   output logic timeout_pulse
);
   localparam int SEL_W = $clog2(N_SLAVES);
   localparam int IDX_W = $clog2(N_MASTERS);
   localparam int CNT_W = $clog2(SEL_W) + 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_ACK,
      S_CONN,
      S_CLEAN
   } state_t;

   state_t           state;
   logic [IDX_W-1:0] gnt_idx;
   logic [IDX_W-1:0] rr_ptr;
   logic [IDX_W-1:0] pick;
   logic [IDX_W:0]   cand;
   logic             found;
   logic [SEL_W-1:0] sel;
   logic [CNT_W-1:0] bit_cnt;
   logic             g_req;
   logic             g_mvalid;
   logic             sel_ok;

`ifdef ARB_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT);
   logic [TO_W-1:0] idle_cnt;
   logic            to_q;
   assign timeout_pulse = to_q;
`else
   assign timeout_pulse = 1'b0;
`endif

   assign g_req    = bus.m_req[gnt_idx];
   assign g_mvalid = bus.m_master_valid[gnt_idx];
   assign sel_ok   = {1'b0, sel} < (SEL_W+1)'(N_SLAVES);

   // first requester at or after rr_ptr, wrapping
   always_comb begin
      pick  = rr_ptr;
      found = 1'b0;
      cand  = '0;
      for (int i = 0; i < N_MASTERS; i++) begin
         cand = {1'b0, rr_ptr} + (IDX_W+1)'(i);
         if (cand >= (IDX_W+1)'(N_MASTERS))
            cand = cand - (IDX_W+1)'(N_MASTERS);
         if (!found && bus.m_req[cand[IDX_W-1:0]]) begin
            pick  = cand[IDX_W-1:0];
            found = 1'b1;
         end
      end
   end

   // arbitration / address / connection state machine
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         gnt_idx <= '0;
         rr_ptr  <= '0;
         sel     <= '0;
         bit_cnt <= '0;
`ifdef ARB_TIMEOUT_EN
         idle_cnt <= '0;
         to_q     <= 1'b0;
`endif
      end else begin
`ifdef ARB_TIMEOUT_EN
         to_q <= 1'b0;
`endif
         unique case (state)
            S_IDLE: begin
               if (found) begin
                  gnt_idx <= pick;
                  if (pick == IDX_W'(N_MASTERS-1))
                     rr_ptr <= '0;
                  else
                     rr_ptr <= pick + 1'b1;
                  state <= S_ADDR;
               end
            end
            S_ADDR: begin
               if (!g_req) begin
                  state <= S_CLEAN;
               end else if (g_mvalid) begin
                  sel     <= SEL_W'({sel, bus.m_wr_bus[gnt_idx]});
                  bit_cnt <= bit_cnt + 1'b1;
                  if (bit_cnt == CNT_W'(SEL_W-1))
                     state <= S_ACK;
               end
            end
            S_ACK: begin
               state <= (g_req && sel_ok) ? S_CONN : S_CLEAN;
            end
            S_CONN: begin
               if (!g_req) begin
                  state <= S_CLEAN;
`ifdef ARB_TIMEOUT_EN
               end else if (g_mvalid || bus.s_slave_valid[sel]) begin
                  idle_cnt <= '0;
               end else if (idle_cnt == TO_W'(TIMEOUT-1)) begin
                  state <= S_CLEAN;
                  to_q  <= 1'b1;
               end else begin
                  idle_cnt <= idle_cnt + 1'b1;
`endif
               end
            end
            S_CLEAN: begin
               sel     <= '0;
               bit_cnt <= '0;
`ifdef ARB_TIMEOUT_EN
               idle_cnt <= '0;
`endif
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // grant, ack and zero-latency routing from registered gnt_idx/sel
   always_comb begin
      bus.m_grant        = '0;
      bus.m_ack          = '0;
      bus.m_rd_bus       = '0;
      bus.m_slave_ready  = '0;
      bus.m_slave_valid  = '0;
      bus.s_mode         = '0;
      bus.s_wr_bus       = '0;
      bus.s_master_valid = '0;
      bus.s_master_ready = '0;
      unique case (state)
         S_ADDR: begin
            bus.m_grant[gnt_idx]       = 1'b1;
            bus.m_slave_ready[gnt_idx] = 1'b1;
         end
         S_ACK: begin
            bus.m_grant[gnt_idx] = 1'b1;
            bus.m_ack[gnt_idx]   = g_req & sel_ok;
         end
         S_CONN: begin
            bus.m_grant[gnt_idx] = 1'b1;
            bus.m_ack[gnt_idx]   = 1'b1;
            bus.s_mode[sel]         = bus.m_mode[gnt_idx];
            bus.s_wr_bus[sel]       = bus.m_wr_bus[gnt_idx];
            bus.s_master_valid[sel] = g_mvalid;
            bus.s_master_ready[sel] = bus.m_master_ready[gnt_idx];
            bus.m_rd_bus[gnt_idx]      = bus.s_rd_bus[sel];
            bus.m_slave_ready[gnt_idx] = bus.s_slave_ready[sel];
            bus.m_slave_valid[gnt_idx] = bus.s_slave_valid[sel];
         end
         default: ;
      endcase
   end
endmodule

// File: tb/tb_serial_bus_arbiter_rr.sv
// Bench for serial_bus_arbiter_rr: directed transactions, per-transaction
// scoreboard records checked by monitors, plus direct timing/routing checks.
module tb_serial_bus_arbiter_rr;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic tp4;
   logic tp3;

   always #5 clk = ~clk;

   serial_bus_arbiter_rr_if #(.N_MASTERS(2), .N_SLAVES(4)) bus4 ();
   serial_bus_arbiter_rr_if #(.N_MASTERS(2), .N_SLAVES(3)) bus3 ();

   serial_bus_arbiter_rr #(.N_MASTERS(2), .N_SLAVES(4), .TIMEOUT(8)) dut4 (
      .clk(clk), .rst(rst), .bus(bus4), .timeout_pulse(tp4)
   );
   serial_bus_arbiter_rr #(.N_MASTERS(2), .N_SLAVES(3), .TIMEOUT(8)) dut3 (
      .clk(clk), .rst(rst), .bus(bus3), .timeout_pulse(tp3)
   );

   // g: grant seen, ack: any m_ack, sm: slaves driven, mm: masters driven
   typedef struct packed {
      logic [1:0] g;
      logic       ack;
      logic [3:0] sm;
      logic [1:0] mm;
      logic       tp;
   } rec_t;

   rec_t q4[$];
   rec_t q3[$];
   int total = 0;
   int bad = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   function automatic rec_t mk(input int m, input logic ack,
                               input logic [3:0] sm, input logic tp);
      rec_t r;
      r.g   = 2'(1 << m);
      r.ack = ack;
      r.sm  = sm;
      r.mm  = 2'(1 << m);
      r.tp  = tp;
      return r;
   endfunction

   // monitor: accumulate one grant interval of dut4, compare on release
   initial begin : mon4
      rec_t cur;
      rec_t ex;
      logic on;
      cur = '0;
      on = 1'b0;
      forever begin
         @(negedge clk);
         if (!on && bus4.m_grant != 0) begin
            on = 1'b1;
            cur = '0;
         end
         if (on) begin
            cur.g   |= bus4.m_grant;
            cur.ack |= |bus4.m_ack;
            cur.sm  |= bus4.s_mode | bus4.s_wr_bus |
                       bus4.s_master_valid | bus4.s_master_ready;
            cur.mm  |= bus4.m_ack | bus4.m_slave_ready |
                       bus4.m_slave_valid | bus4.m_rd_bus;
            cur.tp  |= tp4;
            if (bus4.m_grant == 0) begin
               on = 1'b0;
               if (q4.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL mon4 extra txn: got %0h want none", cur);
               end else begin
                  ex = q4.pop_front();
                  chk("mon4 txn", 32'(cur), 32'(ex));
               end
            end
         end
      end
   end

   // monitor: same for the three-slave instance
   initial begin : mon3
      rec_t cur;
      rec_t ex;
      logic on;
      cur = '0;
      on = 1'b0;
      forever begin
         @(negedge clk);
         if (!on && bus3.m_grant != 0) begin
            on = 1'b1;
            cur = '0;
         end
         if (on) begin
            cur.g   |= bus3.m_grant;
            cur.ack |= |bus3.m_ack;
            cur.sm  |= {1'b0, bus3.s_mode | bus3.s_wr_bus |
                        bus3.s_master_valid | bus3.s_master_ready};
            cur.mm  |= bus3.m_ack | bus3.m_slave_ready |
                       bus3.m_slave_valid | bus3.m_rd_bus;
            cur.tp  |= tp3;
            if (bus3.m_grant == 0) begin
               on = 1'b0;
               if (q3.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL mon3 extra txn: got %0h want none", cur);
               end else begin
                  ex = q3.pop_front();
                  chk("mon3 txn", 32'(cur), 32'(ex));
               end
            end
         end
      end
   end

   // wait for grant, send 2 address bits, check ack, step past ACK
   task automatic conn4(input int m, input logic [1:0] a,
                        input logic exp_ack, output int n);
      n = 0;
      while (bus4.m_grant == 0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("grant", 32'(bus4.m_grant), 32'(1 << m));
      for (int b = 1; b >= 0; b--) begin
         bus4.m_master_valid[m] = 1'b1;
         bus4.m_wr_bus[m] = a[b];
         @(negedge clk);
      end
      bus4.m_master_valid[m] = 1'b0;
      bus4.m_wr_bus[m] = 1'b0;
      chk("ack", 32'(bus4.m_ack), exp_ack ? 32'(1 << m) : 32'd0);
      @(negedge clk);
   endtask

   task automatic traffic4(input int m, input int cyc);
      for (int c = 0; c < cyc; c++) begin
         bus4.m_master_valid[m] = 1'b1;
         bus4.m_wr_bus[m] = c[0];
         @(negedge clk);
      end
   endtask

   task automatic rel4(input int m, input logic rereq);
      bus4.m_req[m] = 1'b0;
      bus4.m_master_valid[m] = 1'b0;
      bus4.m_wr_bus[m] = 1'b0;
      @(negedge clk);
      chk("clean grant", 32'(bus4.m_grant), 32'd0);
      if (rereq) bus4.m_req[m] = 1'b1;
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: sim time exceeded");
      $fatal(1);
   end

   initial begin : stim
      int n;
      int ms[4];
      logic [1:0] as[4];
      logic seen;
      ms = '{1, 0, 1, 0};
      as = '{2'd0, 2'd1, 2'd3, 2'd2};
      bus4.m_req = '0; bus4.m_mode = '0; bus4.m_wr_bus = '0;
      bus4.m_master_valid = '0; bus4.m_master_ready = '0;
      bus4.s_rd_bus = '0; bus4.s_slave_ready = '0;
      bus4.s_slave_valid = '0;
      bus3.m_req = '0; bus3.m_mode = '0; bus3.m_wr_bus = '0;
      bus3.m_master_valid = '0; bus3.m_master_ready = '0;
      bus3.s_rd_bus = '0; bus3.s_slave_ready = '0;
      bus3.s_slave_valid = '0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst grant", 32'(bus4.m_grant), 0);
      chk("rst ack", 32'(bus4.m_ack), 0);
      chk("rst s_valid", 32'(bus4.s_master_valid), 0);
      chk("rst tp", 32'(tp4), 0);

      // basic connect: master 0 to slave 2
      rst = 1'b0;
      bus4.m_req = 2'b01;
      q4.push_back(mk(0, 1'b1, 4'b0100, 1'b0));
      @(negedge clk);
      chk("t1 grant latency", 32'(bus4.m_grant), 32'b01);
      conn4(0, 2'b10, 1'b1, n);
      bus4.m_master_valid[0] = 1'b1;
      bus4.m_wr_bus[0] = 1'b1;
      bus4.m_mode[0] = 1'b1;
      bus4.m_master_ready[0] = 1'b1;
      bus4.s_rd_bus = 4'b0100;
      bus4.s_slave_valid = 4'b1011;
      bus4.s_slave_ready = 4'b0100;
      #1;
      chk("t1 s_wr_bus", 32'(bus4.s_wr_bus), 32'b0100);
      chk("t1 s_valid", 32'(bus4.s_master_valid), 32'b0100);
      chk("t1 s_mode", 32'(bus4.s_mode), 32'b0100);
      chk("t1 s_mready", 32'(bus4.s_master_ready), 32'b0100);
      chk("t1 m_rd_bus", 32'(bus4.m_rd_bus), 32'b01);
      chk("t1 m_svalid", 32'(bus4.m_slave_valid), 32'b00);
      chk("t1 m_sready", 32'(bus4.m_slave_ready), 32'b01);
      bus4.m_wr_bus[0] = 1'b0;
      bus4.s_slave_valid = 4'b0100;
      #1;
      chk("t1 s_wr_bus lo", 32'(bus4.s_wr_bus), 0);
      chk("t1 m_svalid hi", 32'(bus4.m_slave_valid), 32'b01);
      bus4.m_mode = '0;
      bus4.m_master_ready = '0;
      bus4.s_rd_bus = '0;
      bus4.s_slave_valid = '0;
      bus4.s_slave_ready = '0;
      @(negedge clk);
      rel4(0, 1'b0);
      @(negedge clk);

      // both masters requesting: grants alternate from rr_ptr
      bus4.m_req = 2'b11;
      for (int k = 0; k < 4; k++) begin
         q4.push_back(mk(ms[k], 1'b1, 4'(1 << as[k]), 1'b0));
         conn4(ms[k], as[k], 1'b1, n);
         chk("rr wait", 32'(n), (k == 0) ? 32'd1 : 32'd2);
         traffic4(ms[k], 3);
         if (k == 3) bus4.m_req[1] = 1'b0;
         rel4(ms[k], k != 3);
      end
      @(negedge clk);

      // three slaves: address 3 is rejected, address 2 accepted
      q3.push_back(mk(0, 1'b0, 4'b0000, 1'b0));
      bus3.m_req = 2'b01;
      @(negedge clk);
      chk("nack grant", 32'(bus3.m_grant), 32'b01);
      bus3.m_master_valid[0] = 1'b1;
      bus3.m_wr_bus[0] = 1'b1;
      repeat (2) @(negedge clk);
      bus3.m_master_valid[0] = 1'b0;
      bus3.m_wr_bus[0] = 1'b0;
      chk("nack ack", 32'(bus3.m_ack), 0);
      chk("nack grant ack", 32'(bus3.m_grant), 32'b01);
      @(negedge clk);
      chk("nack clean", 32'(bus3.m_grant), 0);
      bus3.m_req = 2'b00;
      @(negedge clk);
      q3.push_back(mk(0, 1'b1, 4'b0100, 1'b0));
      bus3.m_req = 2'b01;
      @(negedge clk);
      bus3.m_master_valid[0] = 1'b1;
      bus3.m_wr_bus[0] = 1'b1;
      @(negedge clk);
      bus3.m_wr_bus[0] = 1'b0;
      @(negedge clk);
      bus3.m_master_valid[0] = 1'b0;
      chk("s3 ack", 32'(bus3.m_ack), 32'b01);
      @(negedge clk);
      bus3.m_master_valid[0] = 1'b1;
      #1;
      chk("s3 route", 32'(bus3.s_master_valid), 32'b100);
      @(negedge clk);
      bus3.m_master_valid[0] = 1'b0;
      bus3.m_req = 2'b00;
      repeat (2) @(negedge clk);

      // abort after one address bit, then master 1 at earliest idle
      q4.push_back(mk(0, 1'b0, 4'b0000, 1'b0));
      q4.push_back(mk(1, 1'b1, 4'b1000, 1'b0));
      bus4.m_req = 2'b01;
      @(negedge clk);
      chk("abort grant", 32'(bus4.m_grant), 32'b01);
      bus4.m_master_valid[0] = 1'b1;
      bus4.m_wr_bus[0] = 1'b1;
      @(negedge clk);
      bus4.m_req = 2'b10;
      bus4.m_master_valid[0] = 1'b0;
      bus4.m_wr_bus[0] = 1'b0;
      @(negedge clk);
      chk("abort clean", 32'(bus4.m_grant), 0);
      @(negedge clk);
      chk("abort idle", 32'(bus4.m_grant), 0);
      @(negedge clk);
      chk("abort next grant", 32'(bus4.m_grant), 32'b10);
      conn4(1, 2'd3, 1'b1, n);
      traffic4(1, 2);
      rel4(1, 1'b0);
      @(negedge clk);

      // idle connection: timeout release or indefinite hold
`ifdef ARB_TIMEOUT_EN
      q4.push_back(mk(0, 1'b1, 4'b0000, 1'b1));
`else
      q4.push_back(mk(0, 1'b1, 4'b0000, 1'b0));
`endif
      bus4.m_req = 2'b01;
      conn4(0, 2'd1, 1'b1, n);
`ifdef ARB_TIMEOUT_EN
      n = 0;
      while (!tp4 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("timeout cycles", 32'(n), 32'd8);
      chk("timeout grant", 32'(bus4.m_grant), 0);
      bus4.m_req = 2'b00;
      @(negedge clk);
      chk("timeout pulse width", 32'(tp4), 0);
`else
      seen = 1'b0;
      repeat (110) begin
         @(negedge clk);
         seen |= tp4;
      end
      chk("persist grant", 32'(bus4.m_grant), 32'b01);
      chk("persist ack", 32'(bus4.m_ack), 32'b01);
      chk("persist tp", 32'(seen), 0);
      rel4(0, 1'b0);
`endif
      @(negedge clk);

      // reset while connected, then rr_ptr restarts at master 0
      q4.push_back(mk(0, 1'b1, 4'b0001, 1'b0));
      bus4.m_req = 2'b01;
      conn4(0, 2'd0, 1'b1, n);
      bus4.m_master_valid[0] = 1'b1;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("mid rst grant", 32'(bus4.m_grant), 0);
      chk("mid rst ack", 32'(bus4.m_ack), 0);
      chk("mid rst s_valid", 32'(bus4.s_master_valid), 0);
      chk("mid rst sready", 32'(bus4.m_slave_ready), 0);
      bus4.m_master_valid[0] = 1'b0;
      bus4.m_req = 2'b11;
      rst = 1'b0;
      q4.push_back(mk(0, 1'b1, 4'b0010, 1'b0));
      q4.push_back(mk(1, 1'b1, 4'b0100, 1'b0));
      @(negedge clk);
      chk("post rst grant", 32'(bus4.m_grant), 32'b01);
      conn4(0, 2'd1, 1'b1, n);
      traffic4(0, 2);
      rel4(0, 1'b0);
      conn4(1, 2'd2, 1'b1, n);
      traffic4(1, 2);
      rel4(1, 1'b0);
      repeat (3) @(negedge clk);

      chk("q4 drained", 32'(q4.size()), 0);
      chk("q3 drained", 32'(q3.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
